imem_responder: RTL and testbench
=================================

IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter WAIT_STATES, default 2, range 0..7: idle cycles between request acceptance and the memory read.
REQ-002 Parameter DEPTH, default 256: number of 32-bit instruction words.
REQ-003 clk  input  1  single clock, all state updates on posedge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  1  fetch stage presents a word address.
REQ-006 req_addr  input  8  word address (same 8-bit PC encoding the fetch stage drives).
REQ-007 req_ready  output  1  responder can accept a request.
REQ-008 rsp_valid  output  1  rsp_data holds the fetched instruction.
REQ-009 rsp_data  output  32  instruction word.
REQ-010 rsp_ready  input  1  fetch stage consumes the response.
REQ-011 load_en  input  1  program-load write strobe.
REQ-012 load_addr  input  8  program-load word address.
REQ-013 load_data  input  32  program-load word.
REQ-014 rsp_count  output  8  number of completed responses, modulo 256.

Function
REQ-015 The FSM SHALL have three states: IDLE, WAIT, RESP.
REQ-016 In IDLE, req_ready SHALL be 1 and rsp_valid 0; in WAIT and RESP, req_ready SHALL be 0.
REQ-017 In IDLE, req_valid=1 SHALL capture req_addr into an address register; next state is WAIT with counter=WAIT_STATES-1, or RESP when WAIT_STATES=0.
REQ-018 In WAIT, the counter SHALL decrement each cycle; when it is 0, next state is RESP.
REQ-019 On entry to RESP, rsp_data SHALL be loaded from mem[captured address]; the memory read occurs on the transition edge.
REQ-020 Latency SHALL be WAIT_STATES+1 cycles from the accepting edge to the first cycle with rsp_valid=1.
REQ-021 In RESP, rsp_valid SHALL be 1 and rsp_data SHALL stay stable until the edge with rsp_ready=1; that edge returns the FSM to IDLE and increments rsp_count.
REQ-022 rsp_count SHALL wrap from 255 to 0.
REQ-023 No back-to-back acceptance: a new request SHALL be accepted no earlier than the cycle after the response handshake.
REQ-024 load_en=1 SHALL write load_data to mem[load_addr] on the posedge, in any state.
REQ-025 A load to the captured address during WAIT (or on the read edge itself) SHALL be visible in rsp_data; write-before-read applies on the same edge.
REQ-026 A load during RESP SHALL NOT alter the held rsp_data.
REQ-027 Addresses SHALL index mem directly; no byte-offset shift is applied.
REQ-028 rsp_ready while not in RESP SHALL be ignored.

Reset
REQ-029 rst_n=0 SHALL force IDLE immediately, with req_ready=1, rsp_valid=0, rsp_data=0, rsp_count=0, counter=0, and captured address=0.
REQ-030 Reset mid-WAIT or mid-RESP SHALL drop the pending transaction with no response.
REQ-031 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-032 A shared package SHALL hold the state enum (IDLE/WAIT/RESP), the word-width constant 32, and the address-width constant 8.
REQ-033 Storage SHALL be one sub-module, imem_array: a synchronous-write, asynchronous-read 32xDEPTH array.

Verification
REQ-034 Reset release, load mem[5]=0x2002000A, request addr 5, rsp_ready=1 -> rsp_valid exactly 3 cycles after acceptance, rsp_data=0x2002000A, rsp_count=1.
REQ-035 WAIT_STATES=0, request addr 0x10 holding 0x8C030004 -> rsp_valid on the next cycle.
REQ-036 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid stays 1, rsp_data is stable, req_ready=0, and a concurrent req_valid is not accepted.
REQ-037 Request addr 7 (old 0x11111111), load mem[7]=0x22222222 during WAIT -> rsp_data=0x22222222; a load during RESP leaves rsp_data unchanged.
REQ-038 rst_n asserted mid-WAIT -> outputs return to reset values asynchronously, no response appears, and memory retains its contents.
REQ-039 256 consecutive handshakes, addr 0xFF then 0x00 -> rsp_count wraps to 0 and the correct words are returned.

Source files
------------

// File: rtl/imem_responder_pkg.sv
// Shared types and widths for the instruction-memory responder slice.
package imem_responder_pkg;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/imem_array.sv
// Instruction storage: synchronous write, asynchronous (combinational) read.
module imem_array
  import imem_responder_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // NOTE: no reset on the array; a loaded program must survive a core reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_responder.sv
// Fixed-latency instruction fetch responder with a side program-load port.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int WAIT_STATES = 2,
  parameter int DEPTH       = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_data,
  input  logic              rsp_ready,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [WORD_W-1:0] load_data,
  output logic [7:0]        rsp_count
);

  localparam logic [2:0] CNT_INIT = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

  state_t            state_q, state_d;
  logic [2:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] raddr;
  logic [WORD_W-1:0] mem_rdata;
  logic [WORD_W-1:0] read_word;
  logic [WORD_W-1:0] data_q;
  logic [7:0]        count_q;

  // With zero wait states the read shares the accepting edge, so addr_q is not yet loaded.
  assign raddr = (state_q == IDLE) ? req_addr : addr_q;

  imem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .we    (load_en),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (raddr),
    .rdata (mem_rdata)
  );

  // A load landing on the read edge must win over the stale array word.
  assign read_word = (load_en && (load_addr == raddr)) ? load_data : mem_rdata;

  // NOTE: default assigned first so every path drives state_d and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid) state_d = (WAIT_STATES == 0) ? RESP : WAIT;
      WAIT: if (cnt_q == 3'd0) state_d = RESP;
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      addr_q  <= '0;
      data_q  <= '0;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid) begin
        addr_q <= req_addr;
        cnt_q  <= CNT_INIT;
      end else if (state_q == WAIT && cnt_q != 3'd0) begin
        cnt_q <= cnt_q - 3'd1;
      end
      if (state_d == RESP && state_q != RESP) data_q <= read_word;
      if (state_q == RESP && rsp_ready) count_q <= count_q + 8'd1;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = data_q;
  assign rsp_count = count_q;

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: latency, hold, load hazards, reset, count wrap.
module tb_imem_responder;

  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, load_en;
  logic [7:0]  req_addr, load_addr, rsp_count;
  logic [31:0] rsp_data, load_data;

  logic        req_valid_z, req_ready_z, rsp_valid_z, rsp_ready_z, load_en_z;
  logic [7:0]  req_addr_z, load_addr_z, rsp_count_z;
  logic [31:0] rsp_data_z, load_data_z;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] model_mem [256];
  logic [31:0] exp_q [$];
  logic [7:0]  exp_count;

  always #5 clk = ~clk;

  imem_responder #(.WAIT_STATES(WS), .DEPTH(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .rsp_count(rsp_count)
  );

  imem_responder #(.WAIT_STATES(0), .DEPTH(256)) dut_z (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_z), .req_addr(req_addr_z), .req_ready(req_ready_z),
    .rsp_valid(rsp_valid_z), .rsp_data(rsp_data_z), .rsp_ready(rsp_ready_z),
    .load_en(load_en_z), .load_addr(load_addr_z), .load_data(load_data_z),
    .rsp_count(rsp_count_z)
  );

  task automatic do_load(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(posedge clk);
    #1 load_en = 1'b0;
    model_mem[a] = d;
  endtask

  // One full transaction. load_edge k>0 issues a load to addr on the k-th edge
  // after the accepting edge; edges up to WS land before/at the read.
  task automatic run_txn(input logic [7:0] addr, input int load_edge,
                         input logic [31:0] ldata, input int hold);
    logic [31:0] exp;
    int lat;
    exp = (load_edge > 0 && load_edge <= WS) ? ldata : model_mem[addr];
    exp_q.push_back(exp);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL req_ready_idle: got %b expected 1", req_ready);
    end
    req_valid = 1'b1; req_addr = addr;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 16) begin
      if (lat == load_edge) begin
        load_en = 1'b1; load_addr = addr; load_data = ldata; model_mem[addr] = ldata;
      end
      @(posedge clk);
      @(negedge clk);
      load_en = 1'b0;
      lat++;
    end
    checks++;
    if (lat != WS + 1) begin
      errors++; $display("FAIL latency addr=%h: got %0d expected %0d", addr, lat, WS + 1);
    end
    exp = exp_q.pop_front();
    checks++;
    if (rsp_data !== exp) begin
      errors++; $display("FAIL rsp_data addr=%h: got %h expected %h", addr, rsp_data, exp);
    end
    for (int h = 0; h < hold; h++) begin
      if (h == 0 && load_edge > WS) begin
        load_en = 1'b1; load_addr = addr; load_data = ldata; model_mem[addr] = ldata;
      end
      req_valid = 1'b1; req_addr = ~addr;
      @(posedge clk);
      @(negedge clk);
      load_en = 1'b0;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold cycle %0d: got valid=%b data=%h ready=%b expected 1 %h 0",
                 h, rsp_valid, rsp_data, req_ready, exp);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_count = exp_count + 8'd1;
    checks++;
    if (rsp_count !== exp_count || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL handshake: got count=%0d valid=%b ready=%b expected %0d 0 1",
               rsp_count, rsp_valid, req_ready, exp_count);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 0; req_addr = 0; rsp_ready = 0; load_en = 0; load_addr = 0; load_data = 0;
    req_valid_z = 0; req_addr_z = 0; rsp_ready_z = 0; load_en_z = 0; load_addr_z = 0; load_data_z = 0;
    exp_count = 8'd0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_count !== 8'h0) begin
      errors++;
      $display("FAIL reset_state: got ready=%b valid=%b data=%h count=%0d expected 1 0 0 0",
               req_ready, rsp_valid, rsp_data, rsp_count);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_count !== 8'h0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_rsp_ready: got count=%0d valid=%b expected 0 0", rsp_count, rsp_valid);
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 256; i++) do_load(8'(i), $urandom);
    do_load(8'h05, 32'h2002000A);
    do_load(8'h07, 32'h11111111);
    run_txn(8'h05, 0, 32'h0, 0);
    checks++;
    if (rsp_count !== 8'd1) begin
      errors++; $display("FAIL basic_count: got %0d expected 1", rsp_count);
    end
  endtask

  task automatic test_wait0();
    @(negedge clk);
    load_en_z = 1'b1; load_addr_z = 8'h10; load_data_z = 32'h8C030004;
    @(negedge clk);
    load_en_z = 1'b0;
    req_valid_z = 1'b1; req_addr_z = 8'h10;
    @(negedge clk);
    req_valid_z = 1'b0;
    checks++;
    if (rsp_valid_z !== 1'b1 || rsp_data_z !== 32'h8C030004) begin
      errors++;
      $display("FAIL wait0_rsp: got valid=%b data=%h expected 1 8c030004", rsp_valid_z, rsp_data_z);
    end
    rsp_ready_z = 1'b1;
    @(negedge clk);
    rsp_ready_z = 1'b0;
    checks++;
    if (rsp_count_z !== 8'd1 || rsp_valid_z !== 1'b0) begin
      errors++;
      $display("FAIL wait0_handshake: got count=%0d valid=%b expected 1 0", rsp_count_z, rsp_valid_z);
    end
  endtask

  task automatic test_hold_and_loads();
    run_txn(8'h20, WS + 1, 32'hDEADBEEF, 5);
    run_txn(8'h20, 0, 32'h0, 0);
    run_txn(8'h07, 1, 32'h22222222, 0);
    run_txn(8'h09, WS, 32'h33333333, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) run_txn(8'(i * 37 + 3), 0, 32'h0, i % 3);
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    req_valid = 1'b1; req_addr = 8'h05;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_count !== 8'h0) begin
      errors++;
      $display("FAIL async_reset: got ready=%b valid=%b data=%h count=%0d expected 1 0 0 0",
               req_ready, rsp_valid, rsp_data, rsp_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_count = 8'd0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++; $display("FAIL dropped_txn cycle %0d: got valid=%b expected 0", i, rsp_valid);
      end
    end
    run_txn(8'h05, 0, 32'h0, 0);
    run_txn(8'h07, 0, 32'h0, 0);
  endtask

  task automatic test_wrap();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_count = 8'd0;
    for (int i = 0; i < 256; i++) run_txn(8'(255 + i), 0, 32'h0, 0);
    checks++;
    if (rsp_count !== 8'd0) begin
      errors++; $display("FAIL count_wrap: got %0d expected 0", rsp_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait0();
    test_hold_and_loads();
    test_back_to_back();
    test_reset_mid_wait();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
